// File: rtl/rrf_commit_pkg.sv
// Shared types and sizing for the in-order retirement stage.
package rrf_commit_pkg;

  localparam int unsigned NUM_ARCH_REGS = 32;
  localparam int unsigned NUM_PHYS_REGS = 64;
  localparam int unsigned PHYS_IDX_W    = $clog2(NUM_PHYS_REGS);
  localparam int unsigned ARCH_IDX_W    = $clog2(NUM_ARCH_REGS);
  localparam int unsigned XLEN          = 32;
  localparam int unsigned CNT_W         = 64;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } commit_state_t;

  // ROB head view presented to the commit stage.
  typedef struct packed {
    logic                  is_empty;
    logic                  commit;
    logic                  regf_we;
    logic [ARCH_IDX_W-1:0] rd_arch;
    logic [PHYS_IDX_W-1:0] rd_phys;
    logic                  is_branch;
    logic [XLEN-1:0]       pred_pc;
    logic [XLEN-1:0]       calc_pc;
  } rob_head_t;

endpackage

// File: rtl/rrf_commit_rrat_table.sv
// Retirement RAT: arch-indexed phys map, one read and one write port,
// identity on reset, flat snapshot for the rename-stage restore.
module rrf_commit_rrat_table
  import rrf_commit_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic [ARCH_IDX_W-1:0]               rd_idx,
  output logic [PHYS_IDX_W-1:0]               rd_data,
  input  logic                                we,
  input  logic [ARCH_IDX_W-1:0]               wr_idx,
  input  logic [PHYS_IDX_W-1:0]               wr_data,
  output logic [NUM_ARCH_REGS*PHYS_IDX_W-1:0] snapshot
);

  logic [PHYS_IDX_W-1:0] map_q [NUM_ARCH_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) begin
        map_q[i] <= PHYS_IDX_W'(i);
      end
    end else if (we) begin
      map_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = map_q[rd_idx];

  for (genvar g = 0; g < NUM_ARCH_REGS; g++) begin : g_snap
    assign snapshot[g*PHYS_IDX_W +: PHYS_IDX_W] = map_q[g];
  end

endmodule

// File: rtl/rrf_commit.sv
// In-order commit: retires the ROB head, updates the RRAT, frees the
// superseded phys reg and raises a one-cycle flush on a mispredict.
module rrf_commit
  import rrf_commit_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                rob_is_empty,
  input  logic                                rob_commit,
  input  logic                                rob_regf_we,
  input  logic [ARCH_IDX_W-1:0]               rob_rd_arch,
  input  logic [PHYS_IDX_W-1:0]               rob_rd_phys,
  input  logic                                rob_is_branch,
  input  logic [XLEN-1:0]                     rob_pred_pc,
  input  logic [XLEN-1:0]                     rob_calc_pc,
  input  logic                                fl_ready,
  output logic                                rob_dequeue,
  output logic                                fl_push,
  output logic [PHYS_IDX_W-1:0]               fl_push_idx,
  output logic                                flush,
  output logic [XLEN-1:0]                     redirect_pc,
  output logic [NUM_ARCH_REGS*PHYS_IDX_W-1:0] rrat_map,
  output logic [CNT_W-1:0]                    retired_cnt
);

  rob_head_t     head;
  commit_state_t state_q, state_d;
  logic          wr, go, mp;

  assign head = '{
    is_empty:  rob_is_empty,
    commit:    rob_commit,
    regf_we:   rob_regf_we,
    rd_arch:   rob_rd_arch,
    rd_phys:   rob_rd_phys,
    is_branch: rob_is_branch,
    pred_pc:   rob_pred_pc,
    calc_pc:   rob_calc_pc
  };

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Commit qualification and next state; held in reset so nothing leaks out.
  always_comb begin
    state_d = state_q;
    wr      = head.regf_we & (head.rd_arch != '0);
    go      = 1'b0;
    mp      = 1'b0;
    unique case (state_q)
      RUN: begin
        go = ~rst & ~head.is_empty & head.commit & (~wr | fl_ready);
        mp = go & head.is_branch & (head.calc_pc != head.pred_pc);
        if (mp) state_d = FLUSH;
      end
      FLUSH: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign rob_dequeue = go;
  assign fl_push     = go & wr;

  // Flush pulse, redirect target and retirement counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
      retired_cnt <= '0;
    end else begin
      flush <= mp;
      if (mp) redirect_pc <= head.calc_pc;
      if (go) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  rrf_commit_rrat_table u_rrat (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (head.rd_arch),
    .rd_data  (fl_push_idx),
    .we       (go & wr),
    .wr_idx   (head.rd_arch),
    .wr_data  (head.rd_phys),
    .snapshot (rrat_map)
  );

endmodule
